// File: rtl/devil_ac_snoop_filter.sv
// devil_ac_snoop_filter: tags ACE AC snoops against type/address filters, queues them, counts them.
// Optional last-matched-snoop capture is built only when DEVIL_AC_LAST_CAPTURE_EN is defined.
module devil_ac_snoop_filter #(
    parameter int ADDR_W     = 44,
    parameter int SNOOP_W    = 4,
    parameter int PROT_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               acvalid,
    output logic               acready,
    input  logic [ADDR_W-1:0]  acaddr,
    input  logic [SNOOP_W-1:0] acsnoop,
    input  logic [PROT_W-1:0]  acprot,
    input  logic               cfg_acflt_en,
    input  logic               cfg_addrflt_en,
    input  logic [SNOOP_W-1:0] cfg_acsnoop,
    input  logic [31:0]        cfg_base_addr,
    input  logic [31:0]        cfg_mem_size,
    input  logic               cnt_clr,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [SNOOP_W-1:0] m_snoop,
    output logic [PROT_W-1:0]  m_prot,
    output logic               m_match,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   snoop_cnt,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               last_vld,
    output logic [ADDR_W-1:0]  last_addr,
    output logic [SNOOP_W-1:0] last_snoop
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int XW = ADDR_W + 1;
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [SNOOP_W-1:0] snoop;
        logic [PROT_W-1:0]  prot;
        logic               match;
    } entry_t;
    entry_t mem_q [FIFO_DEPTH];
    entry_t head;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] snp_cnt_q, snp_cnt_d, mat_cnt_q, mat_cnt_d;
    logic [XW-1:0] addr_x, base_x, lim_x;
    logic push, pop, snp_ok, in_rng, match;
    assign fifo_full = cnt_q == (PW+1)'(FIFO_DEPTH);
    assign acready   = resetn && !fifo_full;
    assign m_valid   = cnt_q != '0;
    assign push      = acvalid && acready;
    assign pop       = m_valid && m_ready;
    assign head      = m_valid ? mem_q[rd_q] : '0;
    assign m_addr    = head.addr;
    assign m_snoop   = head.snoop;
    assign m_prot    = head.prot;
    assign m_match   = head.match;
    assign snoop_cnt = snp_cnt_q;
    assign match_cnt = mat_cnt_q;
    // Window compare is one bit wider than the address so base+size never wraps.
    always_comb begin
        addr_x    = XW'(acaddr);
        base_x    = XW'(cfg_base_addr);
        lim_x     = base_x + XW'(cfg_mem_size);
        snp_ok    = !cfg_acflt_en || (acsnoop == cfg_acsnoop);
        in_rng    = (cfg_mem_size != '0) && (base_x <= addr_x) && (addr_x < lim_x);
        match     = snp_ok && (!cfg_addrflt_en || in_rng);
        wr_d      = push ? wr_q + PW'(1) : wr_q;
        rd_d      = pop ? rd_q + PW'(1) : rd_q;
        cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        snp_cnt_d = cnt_clr ? '0 : (push && !(&snp_cnt_q)) ? snp_cnt_q + CNT_W'(1) : snp_cnt_q;
        mat_cnt_d = cnt_clr ? '0 : (push && match && !(&mat_cnt_q)) ? mat_cnt_q + CNT_W'(1) : mat_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            snp_cnt_q <= '0;
            mat_cnt_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            snp_cnt_q <= snp_cnt_d;
            mat_cnt_q <= mat_cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= '{addr: acaddr, snoop: acsnoop, prot: acprot, match: match};
    end
`ifdef DEVIL_AC_LAST_CAPTURE_EN
    logic last_vld_q, last_vld_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [SNOOP_W-1:0] last_snoop_q, last_snoop_d;
    // A matched capture wins over a same-cycle clear.
    always_comb begin
        last_vld_d   = (push && match) ? 1'b1 : cnt_clr ? 1'b0 : last_vld_q;
        last_addr_d  = (push && match) ? acaddr : last_addr_q;
        last_snoop_d = (push && match) ? acsnoop : last_snoop_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_vld_q   <= 1'b0;
            last_addr_q  <= '0;
            last_snoop_q <= '0;
        end else begin
            last_vld_q   <= last_vld_d;
            last_addr_q  <= last_addr_d;
            last_snoop_q <= last_snoop_d;
        end
    end
    assign last_vld   = last_vld_q;
    assign last_addr  = last_addr_q;
    assign last_snoop = last_snoop_q;
`else
    assign last_vld   = 1'b0;
    assign last_addr  = '0;
    assign last_snoop = '0;
`endif
endmodule

// File: tb/tb_devil_ac_snoop_filter.sv
// tb_devil_ac_snoop_filter: scoreboard bench with directed and randomized snoops against a window/type model.
module tb_devil_ac_snoop_filter;
    localparam int AW = 44, SW = 4, PW = 3, D = 4, CW = 8;
    logic clk = 1'b0, resetn = 1'b0, acvalid = 1'b0, acready;
    logic [AW-1:0] acaddr = '0;
    logic [SW-1:0] acsnoop = '0;
    logic [PW-1:0] acprot = '0;
    logic cfg_acflt_en = 1'b0, cfg_addrflt_en = 1'b0;
    logic [SW-1:0] cfg_acsnoop = '0;
    logic [31:0] cfg_base_addr = '0, cfg_mem_size = '0;
    logic cnt_clr = 1'b0, m_valid, m_ready = 1'b0, m_match, fifo_full, last_vld;
    logic [AW-1:0] m_addr, last_addr;
    logic [SW-1:0] m_snoop, last_snoop;
    logic [PW-1:0] m_prot;
    logic [CW-1:0] snoop_cnt, match_cnt;
    always #5 clk = ~clk;
    devil_ac_snoop_filter #(.ADDR_W(AW), .SNOOP_W(SW), .PROT_W(PW), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .acvalid(acvalid), .acready(acready), .acaddr(acaddr),
        .acsnoop(acsnoop), .acprot(acprot), .cfg_acflt_en(cfg_acflt_en), .cfg_addrflt_en(cfg_addrflt_en),
        .cfg_acsnoop(cfg_acsnoop), .cfg_base_addr(cfg_base_addr), .cfg_mem_size(cfg_mem_size),
        .cnt_clr(cnt_clr), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_snoop(m_snoop),
        .m_prot(m_prot), .m_match(m_match), .fifo_full(fifo_full), .snoop_cnt(snoop_cnt),
        .match_cnt(match_cnt), .last_vld(last_vld), .last_addr(last_addr), .last_snoop(last_snoop));
    typedef struct { logic [AW-1:0] a; logic [SW-1:0] s; logic [PW-1:0] p; logic m; } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0, occ = 0;
    logic [CW-1:0] exp_snp = '0, exp_mat = '0;
    logic e_lv = 1'b0;
    logic [AW-1:0] e_la = '0;
    logic [SW-1:0] e_ls = '0;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask
    function automatic bit model_match(input logic [AW-1:0] a, input logic [SW-1:0] s);
        longint unsigned av = 64'(a);
        longint unsigned lo = 64'(cfg_base_addr);
        longint unsigned hi = lo + 64'(cfg_mem_size);
        bit snp_ok = !cfg_acflt_en || (s == cfg_acsnoop);
        bit in_rng = (av >= lo) && (av < hi);
        return snp_ok && (!cfg_addrflt_en || in_rng);
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (resetn && m_valid === 1'b1 && m_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got addr 0x%0h with empty scoreboard", m_addr);
            end else begin
                e = sb.pop_front();
                chk("m_addr", 64'(m_addr), 64'(e.a));
                chk("m_snoop", 64'(m_snoop), 64'(e.s));
                chk("m_prot", 64'(m_prot), 64'(e.p));
                chk("m_match", 64'(m_match), 64'(e.m));
            end
        end
    end
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [SW-1:0] s,
                        input logic [PW-1:0] p, input logic rdy, input logic clr);
        bit push, pop, mt;
        acvalid = v; acaddr = a; acsnoop = s; acprot = p; m_ready = rdy; cnt_clr = clr;
        @(negedge clk);
        chk("acready", 64'(acready), 64'(occ < D));
        chk("fifo_full", 64'(fifo_full), 64'(occ == D));
        chk("m_valid", 64'(m_valid), 64'(occ > 0));
        if (occ == 0) chk("m_idle_fields", 64'({m_addr, m_snoop, m_prot, m_match}), 64'(0));
        chk("snoop_cnt", 64'(snoop_cnt), 64'(exp_snp));
        chk("match_cnt", 64'(match_cnt), 64'(exp_mat));
`ifdef DEVIL_AC_LAST_CAPTURE_EN
        chk("last_vld", 64'(last_vld), 64'(e_lv));
        chk("last_addr", 64'(last_addr), 64'(e_la));
        chk("last_snoop", 64'(last_snoop), 64'(e_ls));
`else
        chk("last_tied", 64'({last_vld, last_addr, last_snoop}), 64'(0));
`endif
        push = v && occ < D;
        pop = occ > 0 && rdy;
        mt = model_match(a, s);
        if (push) sb.push_back('{a: a, s: s, p: p, m: mt});
        exp_snp = clr ? '0 : (push && exp_snp != '1) ? exp_snp + 1'b1 : exp_snp;
        exp_mat = clr ? '0 : (push && mt && exp_mat != '1) ? exp_mat + 1'b1 : exp_mat;
`ifdef DEVIL_AC_LAST_CAPTURE_EN
        if (push && mt) begin
            e_lv = 1'b1; e_la = a; e_ls = s;
        end else if (clr) e_lv = 1'b0;
`endif
        occ += int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        resetn = 1'b0;
        acvalid = 1'b1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("acready_in_reset", 64'(acready), 64'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        acvalid = 1'b0;
        sb.delete();
        occ = 0; exp_snp = '0; exp_mat = '0;
        e_lv = 1'b0; e_la = '0; e_ls = '0;
    endtask
    function automatic logic [AW-1:0] gen_addr();
        logic [63:0] r;
        longint off;
        if ($urandom_range(0, 7) == 0) begin
            r = {$urandom, $urandom};
            return r[AW-1:0];
        end
        off = longint'($urandom_range(0, (cfg_mem_size > 4096 ? 4096 : cfg_mem_size) + 16)) - 8;
        r = 64'(cfg_base_addr) + 64'(off);
        return r[AW-1:0];
    endfunction
    task automatic rand_cfg();
        int b = $urandom_range(0, 3), z = $urandom_range(0, 3);
        cfg_acflt_en = 1'($urandom);
        cfg_addrflt_en = 1'($urandom);
        cfg_acsnoop = SW'($urandom_range(0, 3));
        cfg_base_addr = b == 0 ? 32'h4000_0000 : b == 1 ? 32'hFFFF_FFF0 : b == 2 ? 32'h0 : $urandom;
        cfg_mem_size = z == 0 ? 32'h0 : z == 1 ? 32'h4 : z == 2 ? 32'h20 : 32'($urandom_range(1, 4096));
    endtask
    task automatic rand_step(input bit allow_clr);
        step(1'($urandom_range(0, 3) != 0), gen_addr(), SW'($urandom_range(0, 3)), PW'($urandom),
             1'($urandom_range(0, 2) != 0), allow_clr && $urandom_range(0, 63) == 0);
    endtask
    initial begin
        @(posedge clk);
        #1;
        do_reset();
        cfg_acflt_en = 1; cfg_addrflt_en = 1; cfg_acsnoop = 1;
        cfg_base_addr = 32'h4000_0000; cfg_mem_size = 4;
        step(1, 44'h040000000, 1, 3, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 44'h040000003, 1, 1, 1, 0);
        step(1, 44'h040000004, 1, 2, 1, 0);
        step(1, 44'h03FFFFFFF, 1, 4, 1, 0);
        step(1, 44'h040000000, 0, 5, 1, 0);
        cfg_acflt_en = 0; cfg_addrflt_en = 0;
        step(1, 44'h123456789AB, 7, 6, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, AW'(44'h0A0 + i), SW'(i), PW'(i), 0, 0);
        step(1, 44'h0B0, 1, 1, 0, 0);
        step(1, 44'h0B1, 1, 1, 1, 0);
        step(1, 44'h0B2, 2, 2, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1, 0);
        cfg_acflt_en = 0; cfg_addrflt_en = 1; cfg_base_addr = 32'hFFFF_FFF0; cfg_mem_size = 32'h20;
        step(1, 44'h100000005, 2, 0, 1, 0);
        step(1, 44'h000000005, 2, 0, 1, 0);
        step(1, 44'hFFFFFFF0, 3, 0, 1, 1);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, AW'(44'h100000000 + i), 1, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        cfg_acflt_en = 0; cfg_addrflt_en = 0;
        repeat (300) step(1, gen_addr(), 1, 0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) rand_cfg();
            if ($urandom_range(0, 299) == 0) do_reset();
            rand_step(1);
        end
        for (int i = 0; i < 10 && occ > 0; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
